// File: rtl/word_buffer_pkg.sv
// Shared defaults and elaboration helpers for the word_buffer FIFO slice.
package word_buffer_pkg;

  localparam int WB_DEFAULT_N     = 8;
  localparam int WB_DEFAULT_DEPTH = 4;

  // True when d is a power of two and at least 2 (pointer wrap relies on it).
  function automatic bit wb_depth_ok(input int d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

endpackage

// File: rtl/word_buffer_mem.sv
// DEPTH x N register array: one synchronous write port, one combinational read port.
module word_buffer_mem
  import word_buffer_pkg::*;
#(
  parameter int N     = WB_DEFAULT_N,
  parameter int DEPTH = WB_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem_q [DEPTH];

  // Storage is intentionally not reset; empty status masks stale contents.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/word_buffer.sv
// First-word-fall-through synchronous FIFO with occupancy and peak-occupancy status.
module word_buffer
  import word_buffer_pkg::*;
#(
  parameter int N     = WB_DEFAULT_N,
  parameter int DEPTH = WB_DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   peak
);

  if (!wb_depth_ok(DEPTH)) begin : g_bad_depth
    $error("word_buffer: DEPTH must be a power of two and >= 2");
  end

  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   ONE_C   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic [AW:0]   peak_q,   peak_d;
  logic          push_s, pop_s;

  // Handshakes depend only on registered occupancy, so no loop through in_valid/out_ready.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == {(AW + 1){1'b0}});
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign count     = count_q;
  assign peak      = peak_q;

  // Next-state for pointers, occupancy and peak.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    // count never exceeds DEPTH, so peak saturates there on its own.
    peak_d = (count_d > peak_q) ? count_d : peak_q;
  end

  // State registers; reset discards all stored words and wins over any transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      peak_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      peak_q   <= peak_d;
    end
  end

  word_buffer_mem #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push_s & ~reset),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_ptr_q),
    .rdata (out_data)
  );

endmodule

// File: tb/tb_word_buffer.sv
// Directed bench for word_buffer: scoreboard queue of expected words plus status checks.
module tb_word_buffer;

  localparam int N      = 8;
  localparam int DEPTH  = 4;
  localparam int AW     = 2;
  localparam int PERIOD = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  out_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic [AW:0]   peak;

  int tests = 0;
  int fails = 0;
  logic [N-1:0] sb_q [$];

  always #(PERIOD / 2) clk = ~clk;

  word_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .peak      (peak)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, return 1 time unit after it.
  task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Monitor: mid-cycle, a presented and accepted word must match the scoreboard head.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", {24'h0, out_data}, 32'hDEAD);
      end else begin
        chk("out_word", {24'h0, out_data}, {24'h0, sb_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    #1;
    // 1. reset for two cycles
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_peak", 32'(peak), 32'd0);
    reset = 1'b0;

    // 2. push 11, 22 with consumer stalled
    sb_q.push_back(8'h11); cycle(1'b1, 8'h11, 1'b0);
    chk("lat_out_valid", 32'(out_valid), 32'd1);
    chk("lat_out_data", 32'(out_data), 32'h11);
    sb_q.push_back(8'h22); cycle(1'b1, 8'h22, 1'b0);
    chk("t2_count", 32'(count), 32'd2);
    chk("t2_out_data", 32'(out_data), 32'h11);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t2_drained", 32'(empty), 32'd1);

    // 3. fill with A0..A3, then hold FF while full
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(8'hA0 + 8'(i));
      cycle(1'b1, 8'hA0 + 8'(i), 1'b0);
    end
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b1, 8'hFF, 1'b0);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_in_ready", 32'(in_ready), 32'd0);
    chk("t3_count", 32'(count), 32'd4);
    chk("t3_peak", 32'(peak), 32'd4);
    chk("t3_head", 32'(out_data), 32'hA0);

    // 4. drain; first cycle still offers FF to prove there is no push-through when full
    cycle(1'b1, 8'hFF, 1'b1);
    chk("t4_no_push_through", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1);
    chk("t4_empty", 32'(empty), 32'd1);
    chk("t4_peak", 32'(peak), 32'd4);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t4_pop_empty_ignored", 32'(count), 32'd0);

    // push into empty with out_ready high: cannot pop in the same cycle
    sb_q.push_back(8'hB0); cycle(1'b1, 8'hB0, 1'b1);
    chk("t5_push_empty_count", 32'(count), 32'd1);
    chk("t5_push_empty_data", 32'(out_data), 32'hB0);
    sb_q.push_back(8'hB1); cycle(1'b1, 8'hB1, 1'b0);

    // 5. simultaneous push and pop for 10 cycles
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(8'(i));
      cycle(1'b1, 8'(i), 1'b1);
      chk("t5_count_steady", 32'(count), 32'd2);
    end
    chk("t5_head", 32'(out_data), 32'h08);

    // 6. reset while count=3, out_ready high on the reset edge
    cycle(1'b1, 8'hC0, 1'b0);
    chk("t6_pre_count", 32'(count), 32'd3);
    reset = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    sb_q.delete();
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_peak", 32'(peak), 32'd0);
    reset = 1'b0;
    sb_q.push_back(8'h5A); cycle(1'b1, 8'h5A, 1'b0);
    chk("t6_data", 32'(out_data), 32'h5A);
    chk("t6_count1", 32'(count), 32'd1);
    chk("t6_peak1", 32'(peak), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    chk("t6_empty", 32'(empty), 32'd1);
    cycle(1'b0, 8'h00, 1'b0);
    chk("sb_all_delivered", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
